// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit: single-cycle logic/arith ops plus a 24-step
// shift-add multiplier, sequenced by a small FSM with registered outputs.
//
// state  | meaning
// IDLE   | waiting for Start; operands and opcode latched on accept
// EXEC   | single-cycle op evaluated from latched operands
// MUL    | one multiplier bit per cycle, down-counter sets the terminal step
// DONE   | one-cycle Done pulse, Start ignored
module alu_exec_unit #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUContr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow,
  output logic             IllegalOp,
  output logic             Busy,
  output logic             Done
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_SLT = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum_add, sum_sub;
  logic [WIDTH-1:0]   ex_res;
  logic               ex_c, ex_v, ex_ill;

  assign sum_add  = {1'b0, a_q} + {1'b0, b_q};
  assign sum_sub  = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

  always_comb begin
    ex_res = '0;
    ex_c   = 1'b0;
    ex_v   = 1'b0;
    ex_ill = 1'b0;
    case (op_q)
      OP_AND: ex_res = a_q & b_q;
      OP_OR:  ex_res = a_q | b_q;
      OP_XOR: ex_res = a_q ^ b_q;
      OP_ADD: begin
        ex_res = sum_add[WIDTH-1:0];
        ex_c   = sum_add[WIDTH];
        ex_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_add[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        ex_res = sum_sub[WIDTH-1:0];
        ex_c   = sum_sub[WIDTH];
        ex_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_sub[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT: ex_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: ex_ill = 1'b1;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      cnt       <= '0;
      Result    <= '0;
      Zero      <= 1'b0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
      IllegalOp <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            a_q    <= A;
            b_q    <= B;
            op_q   <= ALUContr;
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            prod   <= '0;
            cnt    <= CW'(WIDTH-1);
            Busy   <= 1'b1;
            state  <= (ALUContr == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          Result    <= ex_res;
          Zero      <= (ex_res == '0);
          Carry     <= ex_c;
          Overflow  <= ex_v;
          IllegalOp <= ex_ill;
          Busy      <= 1'b0;
          Done      <= 1'b1;
          state     <= S_DONE;
        end
        S_MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          // terminal step folds the last partial product straight into Result
          if (cnt == '0) begin
            Result    <= prod_nxt[WIDTH-1:0];
            Zero      <= (prod_nxt[WIDTH-1:0] == '0);
            Carry     <= 1'b0;
            Overflow  <= |prod_nxt[2*WIDTH-1:WIDTH];
            IllegalOp <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: begin
          Done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, datapath width in bits; only WIDTH=24 is supported.
REQ-002 The block SHALL have port Clock, input, 1, sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port Start, input, 1, request to execute one operation, sampled only when Busy=0.
REQ-005 The block SHALL have port ALUContr, input, 4, operation code from the ALU control decoder.
REQ-006 The block SHALL have ports A and B, input, 24 each, operands, captured on the accepted Start cycle.
REQ-007 The block SHALL have port Result, output, 24, registered result, held until the next Done.
REQ-008 The block SHALL have ports Zero, Carry, Overflow, output, 1 each, registered flags updated with Result.
REQ-009 The block SHALL have port IllegalOp, output, 1, registered, set with Done when ALUContr was undefined.
REQ-010 The block SHALL have port Busy, output, 1, high while an accepted operation is not yet complete.
REQ-011 The block SHALL have port Done, output, 1, single-cycle pulse marking Result/flags valid.

Function
REQ-012 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 1010 SUB, 0011 SLT (signed), 0100 XOR, 0101 MUL (unsigned, low 24 bits); all others illegal.
REQ-013 FSM states SHALL be IDLE, EXEC, MUL, DONE; reset state IDLE.
REQ-014 IDLE: Start=1 latches A, B, ALUContr; goes to MUL if opcode is 0101, else EXEC; Start=0 stays IDLE.
REQ-015 EXEC SHALL compute the single-cycle result, load Result/flags, go to DONE; Busy=1 in EXEC.
REQ-016 MUL SHALL be a shift-add multiplier processing one multiplier bit per cycle, exactly 24 cycles, with Busy=1, then load Result/flags and go to DONE.
REQ-017 DONE SHALL assert Done=1 for exactly one cycle, Busy=0, then go to IDLE; Start in DONE is ignored.
REQ-018 Latency: single-cycle ops Done 2 cycles after Start edge; MUL Done 25 cycles after Start edge (24 in MUL + DONE).
REQ-019 Start while Busy=1 SHALL be ignored; operands and opcode of the in-flight operation SHALL NOT change.
REQ-020 Zero SHALL be 1 iff the 24-bit Result is 0, for every opcode.
REQ-021 ADD: Carry = bit 24 of A+B; Overflow = signed overflow (operands same sign, result sign differs).
REQ-022 SUB: computed as A+~B+1; Carry = bit 24 of that sum (1 = no borrow); Overflow = signed overflow (operand signs differ, result sign differs from A).
REQ-023 SLT: Result = 1 if A<B as signed 24-bit, else 0; Carry=0, Overflow=0.
REQ-024 AND/OR/XOR: bitwise result; Carry=0, Overflow=0.
REQ-025 MUL: Result = low 24 bits of 48-bit product; Overflow=1 iff high 24 bits nonzero; Carry=0.
REQ-026 Illegal opcode: Result=0, Zero=1, Carry=0, Overflow=0, IllegalOp=1, via EXEC path; IllegalOp SHALL be 0 on every legal completion.
REQ-027 Result and flags SHALL change only on the cycle entering DONE and SHALL hold otherwise.

Reset
REQ-028 Reset=1 SHALL force state IDLE, Result=0, Zero=0, Carry=0, Overflow=0, IllegalOp=0, Busy=0, Done=0 on the next edge.
REQ-029 Reset SHALL take priority over Start and over any in-flight operation; an aborted MUL SHALL produce no Done.
REQ-030 Start asserted together with Reset SHALL be ignored.

Verification
REQ-031 ADD A=0x7FFFFF, B=0x000001 -> Done at cycle 2, Result=0x800000, Overflow=1, Carry=0, Zero=0.
REQ-032 SUB A=0x000005, B=0x000005 -> Result=0x000000, Zero=1, Carry=1, Overflow=0; SUB A=0, B=1 -> Result=0xFFFFFF, Carry=0.
REQ-033 SLT A=0xFFFFFF(-1), B=0x000001 -> Result=0x000001; swapped operands -> Result=0x000000.
REQ-034 MUL A=0x001000, B=0x001000 -> Busy high 24 cycles, Done at cycle 25, Result=0x000000, Overflow=1, Zero=1; second Start during Busy ignored.
REQ-035 ALUContr=1111 -> Done at cycle 2, IllegalOp=1, Result=0, Zero=1; next legal op clears IllegalOp.
REQ-036 Reset asserted at MUL cycle 10 -> all outputs 0 next cycle, no Done pulse, new Start accepted afterwards.
